jtag_ir_master: RTL and testbench



---
 rtl/jtag_pkg.sv | 50 +++++
 rtl/jtag_ir_master.sv | 127 ++++++++++++
 tb/tb_jtag_ir_master.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// jtag_pkg: shared JTAG definitions.
//   tapState_e       - the 16 IEEE 1149.1 TAP controller states
//   irMasterState_e  - sequencing states of jtag_ir_master
//   TLR_TMS_CYCLES   - TMS=1 cycles that force any TAP into Test-Logic-Reset
//   DEFAULT_IR_WIDTH - default instruction register length
//   tapNext()        - TAP next-state function, driven by TMS
package jtag_pkg;

    localparam int unsigned TLR_TMS_CYCLES   = 5;
    localparam int unsigned DEFAULT_IR_WIDTH = 8;

    typedef enum logic [3:0] {
        TAP_RESET, TAP_IDLE,
        TAP_SEL_DR, TAP_CAP_DR, TAP_SHIFT_DR, TAP_EXIT1_DR,
        TAP_PAUSE_DR, TAP_EXIT2_DR, TAP_UPD_DR,
        TAP_SEL_IR, TAP_CAP_IR, TAP_SHIFT_IR, TAP_EXIT1_IR,
        TAP_PAUSE_IR, TAP_EXIT2_IR, TAP_UPD_IR
    } tapState_e;

    typedef enum logic [3:0] {
        TLR_SEQ, TO_RTI, IDLE, SEL_DR, SEL_IR,
        CAPTURE, SHIFT, EXIT1, UPDATE, DONE
    } irMasterState_e;

    function automatic tapState_e tapNext(input tapState_e cur, input logic tms);
        tapState_e nxt;
        nxt = TAP_RESET;
        case (cur)
            TAP_RESET:    nxt = tms ? TAP_RESET    : TAP_IDLE;
            TAP_IDLE:     nxt = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   nxt = tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_SHIFT_DR: nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
            TAP_EXIT1_DR: nxt = tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
            TAP_EXIT2_DR: nxt = tms ? TAP_UPD_DR   : TAP_SHIFT_DR;
            TAP_UPD_DR:   nxt = tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   nxt = tms ? TAP_RESET    : TAP_CAP_IR;
            TAP_CAP_IR:   nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_SHIFT_IR: nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
            TAP_EXIT1_IR: nxt = tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
            TAP_EXIT2_IR: nxt = tms ? TAP_UPD_IR   : TAP_SHIFT_IR;
            TAP_UPD_IR:   nxt = tms ? TAP_SEL_DR   : TAP_IDLE;
            default:      nxt = TAP_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_ir_master.sv
// jtag_ir_master: loads an instruction into a target TAP instruction register.
//   TCLK, TRESETN - clock shared with the target TAP, async active-low reset
//   start, instr  - load request and instruction word (taken while ready=1)
//   ready         - idle in Run-Test/Idle, able to accept
//   done          - one-cycle pulse when the load completes
//   tdo_data      - word shifted out of the target, LSB = first bit out
//   TMS, TDI, TDO - serial JTAG signals (TMS/TDI registered)
module jtag_ir_master
    import jtag_pkg::*;
#(
    parameter int unsigned IR_WIDTH         = DEFAULT_IR_WIDTH,
    parameter int unsigned RESET_TMS_CYCLES = TLR_TMS_CYCLES
) (
    input  logic                TCLK,
    input  logic                TRESETN,
    input  logic                start,
    input  logic [IR_WIDTH-1:0] instr,
    output logic                ready,
    output logic                done,
    output logic [IR_WIDTH-1:0] tdo_data,
    output logic                TMS,
    output logic                TDI,
    input  logic                TDO
);

    localparam int unsigned CNT_MAX = (IR_WIDTH > RESET_TMS_CYCLES) ? IR_WIDTH : RESET_TMS_CYCLES;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    irMasterState_e      state;
    logic [CW-1:0]       bitCnt;
    logic [IR_WIDTH-1:0] shiftReg;
    logic [IR_WIDTH-1:0] capReg;

    // Because TMS/TDI are registered, each state label names the TAP state the
    // target enters at the end of that cycle. The target therefore sits in
    // Shift-IR one cycle after the master's SHIFT cycles: TDI is presented one
    // cycle late, and TDO is sampled on the edges ending SHIFT counts 1..N-1
    // plus the EXIT1 cycle.
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            state    <= TLR_SEQ;
            bitCnt   <= '0;
            shiftReg <= '0;
            capReg   <= '0;
            TMS      <= 1'b1;
            TDI      <= 1'b0;
            ready    <= 1'b0;
            done     <= 1'b0;
            tdo_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                TLR_SEQ: begin
                    if (bitCnt == CW'(RESET_TMS_CYCLES - 1)) begin
                        bitCnt <= '0;
                        state  <= TO_RTI;
                        TMS    <= 1'b0;
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                TO_RTI: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    TMS   <= 1'b0;
                end
                IDLE: begin
                    if (start) begin
                        state    <= SEL_DR;
                        shiftReg <= instr;
                        ready    <= 1'b0;
                        TMS      <= 1'b1;
                    end
                end
                SEL_DR: begin
                    state <= SEL_IR;
                    TMS   <= 1'b1;
                end
                SEL_IR: begin
                    state <= CAPTURE;
                    TMS   <= 1'b0;
                end
                CAPTURE: begin
                    state <= SHIFT;
                    TMS   <= 1'b0;
                end
                SHIFT: begin
                    TDI      <= shiftReg[0];
                    shiftReg <= shiftReg >> 1;
                    if (bitCnt != '0)
                        capReg <= {TDO, capReg[IR_WIDTH-1:1]};
                    if (bitCnt == CW'(IR_WIDTH - 1)) begin
                        bitCnt <= '0;
                        state  <= EXIT1;
                        TMS    <= 1'b1;
                    end else begin
                        bitCnt <= bitCnt + CW'(1);
                    end
                end
                EXIT1: begin
                    TDI    <= 1'b0;
                    capReg <= {TDO, capReg[IR_WIDTH-1:1]};
                    state  <= UPDATE;
                    TMS    <= 1'b1;
                end
                UPDATE: begin
                    state    <= DONE;
                    TMS      <= 1'b0;
                    done     <= 1'b1;
                    tdo_data <= capReg;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: begin
                    state  <= TLR_SEQ;
                    bitCnt <= '0;
                    TMS    <= 1'b1;
                    TDI    <= 1'b0;
                    ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_ir_master.sv
// tb_jtag_ir_master: directed bench for jtag_ir_master with an attached
// target TAP / instruction-register model and an expected-result queue.
module tb_jtag_ir_master;
    import jtag_pkg::*;

    localparam int unsigned W = 8;

    logic         TCLK = 1'b0;
    logic         TRESETN;
    logic         start;
    logic [W-1:0] instr;
    logic         ready;
    logic         done;
    logic [W-1:0] tdo_data;
    logic         TMS;
    logic         TDI;
    logic         TDO;

    always #5 TCLK = ~TCLK;

    jtag_ir_master #(.IR_WIDTH(W), .RESET_TMS_CYCLES(5)) dut (
        .TCLK(TCLK), .TRESETN(TRESETN), .start(start), .instr(instr),
        .ready(ready), .done(done), .tdo_data(tdo_data),
        .TMS(TMS), .TDI(TDI), .TDO(TDO)
    );

    // Target TAP with an instruction register capturing capVal.
    tapState_e    tapState;
    logic [W-1:0] irSr  = '0;
    logic [W-1:0] po    = '0;
    logic [W-1:0] capVal = '0;
    int           capCnt = 0, shCnt = 0, updCnt = 0, doneCnt = 0;

    assign TDO = irSr[0];

    always @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            tapState <= TAP_RESET;
        end else begin
            case (tapState)
                TAP_CAP_IR:   irSr <= capVal;
                TAP_SHIFT_IR: irSr <= {TDI, irSr[W-1:1]};
                TAP_UPD_IR:   po   <= irSr;
                default: ;
            endcase
            tapState <= tapNext(tapState, TMS);
        end
    end

    always @(posedge TCLK) begin
        if (TRESETN) begin
            if (tapState == TAP_CAP_IR)   capCnt  <= capCnt + 1;
            if (tapState == TAP_SHIFT_IR) shCnt   <= shCnt + 1;
            if (tapState == TAP_UPD_IR)   updCnt  <= updCnt + 1;
            if (done === 1'b1)            doneCnt <= doneCnt + 1;
        end
    end

    typedef struct packed {
        logic [W-1:0] tdo;
        logic [W-1:0] po;
    } exp_t;
    exp_t sb[$];

    int unsigned  nTests = 0;
    int unsigned  nFail  = 0;
    logic [W-1:0] lastPo = '0;
    int           cap0, sh0, upd0, done0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic popCheck(input string tag);
        exp_t e;
        chk({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, " tdo_data"}, 32'(tdo_data), 32'(e.tdo));
            lastPo = e.po;
        end
    endtask

    task automatic snap();
        cap0 = capCnt; sh0 = shCnt; upd0 = updCnt;
    endtask

    task automatic monCheck(input string tag);
        chk({tag, " capture_ir_once"}, 32'(capCnt - cap0), 32'd1);
        chk({tag, " shift_ir_edges"},  32'(shCnt - sh0),   32'(W));
        chk({tag, " update_ir_once"},  32'(updCnt - upd0), 32'd1);
    endtask

    // Called at a negedge with TRESETN low; ends at the first ready negedge.
    task automatic tlrCheck(input string tag);
        TRESETN = 1'b1;
        #1;
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) @(negedge TCLK);
            chk($sformatf("%s tms_c%0d", tag, k),   32'(TMS),   32'(k < 5));
            chk($sformatf("%s ready_c%0d", tag, k), 32'(ready), 32'(k == 6));
        end
        chk({tag, " tdo_data"}, 32'(tdo_data), 32'd0);
    endtask

    // Steps negedges until done, n counts cycles since the accept cycle.
    task automatic waitDone(input string tag, input int unsigned n0, output int unsigned n);
        n = n0;
        do begin
            @(negedge TCLK);
            n++;
        end while (done !== 1'b1 && n < 40);
        chk({tag, " done_seen"}, 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  n;
        logic [W-1:0] ins;
        logic         tmsE, tdiE;

        TRESETN = 1'b0; start = 1'b0; instr = '0;
        repeat (3) @(negedge TCLK);
        chk("rst TMS", 32'(TMS), 32'd1);
        chk("rst TDI", 32'(TDI), 32'd0);
        chk("rst ready", 32'(ready), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst tdo_data", 32'(tdo_data), 32'd0);
        tlrCheck("tlr1");

        // Single load, cycle-by-cycle TMS/TDI/done/ready.
        ins = 8'hA5; instr = ins; start = 1'b1; capVal = 8'h77;
        sb.push_back('{tdo: 8'h77, po: 8'hA5});
        snap();
        for (int k = 1; k <= W + 7; k++) begin
            @(negedge TCLK);
            start = 1'b0;
            tmsE = (k == 1 || k == 2 || k == W + 4 || k == W + 5);
            tdiE = (k >= 5 && k <= W + 4) ? ins[k-5] : 1'b0;
            chk($sformatf("tx1 tms_c%0d", k),   32'(TMS),   32'(tmsE));
            chk($sformatf("tx1 tdi_c%0d", k),   32'(TDI),   32'(tdiE));
            chk($sformatf("tx1 done_c%0d", k),  32'(done),  32'(k == W + 6));
            chk($sformatf("tx1 ready_c%0d", k), 32'(ready), 32'(k == W + 7));
            if (k == W + 6) popCheck("tx1");
        end
        chk("tx1 po", 32'(po), 32'(lastPo));
        monCheck("tx1");

        // Back-to-back with start held high.
        instr = 8'h3C; start = 1'b1; capVal = 8'h5A;
        sb.push_back('{tdo: 8'h5A, po: 8'h3C});
        snap();
        @(negedge TCLK);
        instr = 8'hC3;
        waitDone("b2b1", 1, n);
        chk("b2b1 done_cycle", 32'(n), 32'(W + 6));
        popCheck("b2b1");
        chk("b2b1 ready_at_done", 32'(ready), 32'd0);
        capVal = 8'h96;
        sb.push_back('{tdo: 8'h96, po: 8'hC3});
        @(negedge TCLK);
        chk("b2b1 ready_return", 32'(ready), 32'd1);
        chk("b2b1 po", 32'(po), 32'(lastPo));
        monCheck("b2b1");
        snap();
        @(negedge TCLK);
        start = 1'b0;
        chk("b2b2 accepted", 32'(ready), 32'd0);
        waitDone("b2b2", 1, n);
        chk("b2b2 done_cycle", 32'(n), 32'(W + 6));
        popCheck("b2b2");
        @(negedge TCLK);
        chk("b2b2 ready", 32'(ready), 32'd1);
        chk("b2b2 po", 32'(po), 32'(lastPo));
        monCheck("b2b2");

        // start pulsed while busy is ignored.
        instr = 8'h81; start = 1'b1; capVal = 8'h3E;
        sb.push_back('{tdo: 8'h3E, po: 8'h81});
        snap();
        done0 = doneCnt;
        @(negedge TCLK);
        start = 1'b0;
        repeat (6) @(negedge TCLK);
        instr = 8'hFF; start = 1'b1;
        @(negedge TCLK);
        start = 1'b0; instr = '0;
        waitDone("busy", 8, n);
        chk("busy done_cycle", 32'(n), 32'(W + 6));
        popCheck("busy");
        repeat (20) @(negedge TCLK);
        chk("busy one_done", 32'(doneCnt - done0), 32'd1);
        chk("busy po", 32'(po), 32'(lastPo));
        chk("busy ready", 32'(ready), 32'd1);
        monCheck("busy");

        // Reset asserted at cycle 8 of a sequence.
        instr = 8'h5A; start = 1'b1; capVal = 8'h11;
        done0 = doneCnt;
        @(negedge TCLK);
        start = 1'b0;
        repeat (7) @(negedge TCLK);
        TRESETN = 1'b0;
        #1;
        chk("abort TMS", 32'(TMS), 32'd1);
        chk("abort TDI", 32'(TDI), 32'd0);
        chk("abort ready", 32'(ready), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort tdo_data", 32'(tdo_data), 32'd0);
        repeat (2) @(negedge TCLK);
        tlrCheck("tlr2");
        chk("abort no_done", 32'(doneCnt - done0), 32'd0);
        chk("abort po_kept", 32'(po), 32'(lastPo));

        // Normal load after the aborted one.
        instr = 8'h96; start = 1'b1; capVal = 8'hC3;
        sb.push_back('{tdo: 8'hC3, po: 8'h96});
        snap();
        @(negedge TCLK);
        start = 1'b0;
        waitDone("post", 1, n);
        chk("post done_cycle", 32'(n), 32'(W + 6));
        popCheck("post");
        @(negedge TCLK);
        chk("post po", 32'(po), 32'(lastPo));
        monCheck("post");
        chk("sb empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
